keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x3 matrix keypad, synchronises and debounces it, and produces the 4-bit key
//   code consumed by the alarm controller FSM and key register (key[3:0] of alarmclock_top).
//   Sits directly upstream of alarmclock_top; key holds the debounced code while the key is
//   held, and returns to NOKEY (4'hA) on release.
// PARAMETERS
//   SCAN_DIV         256  clock cycles each column is driven low (column dwell), >= 4
//   DEBOUNCE_FRAMES  4    consecutive identical scan frames required to accept a change, >= 1
//   NOKEY            4'hA code output when no valid key is pressed
// PORTS
//   clock      in   1  system clock
//   reset      in   1  asynchronous, active-low reset
//   row_n      in   4  keypad rows, active-low, asynchronous to clock (external pull-ups)
//   col_n      out  3  keypad column drive, active-low, one-hot-low
//   key        out  4  debounced key code, 0-9 digits, 4'hB '*', 4'hC '#', NOKEY otherwise
//   key_valid  out  1  only with KEYSCAN_VALID_EN: 1-cycle pulse on each accepted new key
// BEHAVIOUR
//   - Reset (reset=0, async): col_n=3'b110, key=NOKEY, key_valid=0; synchronisers, dwell
//     counter, column index, frame accumulator, candidate and debounce count cleared.
//   - row_n passes a 2-flop synchroniser before any use.
//   - Dwell counter counts 0..SCAN_DIV-1 and drives the column index 0->1->2->0.
//     col_n = ~(3'b001 << col_idx).
//   - Rows are sampled on the last dwell cycle of each column (count == SCAN_DIV-1).
//   - Key map (row,col): r0: 1 2 3 | r1: 4 5 6 | r2: 7 8 9 | r3: * 0 #.
//   - Frame: 3 columns. Pressed-key tally for the frame: 0 keys -> frame_code=NOKEY;
//     exactly 1 -> its code; >=2 keys anywhere in the frame -> NOKEY (ghost rejection).
//   - Debounce at frame end: if frame_code==candidate, deb_cnt increments, saturating at
//     DEBOUNCE_FRAMES; else candidate<=frame_code, deb_cnt<=1.
//     When deb_cnt (updated) == DEBOUNCE_FRAMES and candidate != key: key<=candidate.
//   - A release is debounced exactly like a press (NOKEY must be stable for DEBOUNCE_FRAMES).
//   - Latency: key updates on the clock edge ending the DEBOUNCE_FRAMES-th consecutive frame
//     that agrees, plus 2 cycles of synchroniser delay relative to row_n.
//   - Switching directly from key A to key B (no release gap) yields key A -> key B
//     with no NOKEY in between; downstream sees the code change.
//   - Bounce inside a frame window that changes frame_code restarts the count (deb_cnt=1).
//   - The dwell counter wraps freely; the scan never stalls, including while a key is held.
//   - Reset asserted mid-frame aborts the frame; scanning resumes at column 0, dwell 0.
// CONFIGURATION
//   KEYSCAN_VALID_EN defined: key_valid port exists. It pulses high for one cycle, in the same
//     cycle key takes a new non-NOKEY value. It does not pulse on return to NOKEY.
//   KEYSCAN_VALID_EN undefined: key_valid port and its logic are absent. key is unchanged.
// TESTING  (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame = 12 cycles)
//   1 Reset low mid-scan -> col_n=3'b110, key=4'hA immediately, asynchronously. Release ->
//     col_n steps 110,101,011 every 4 cycles.
//   2 Hold '5' (row1 low while col1 driven) steady -> key=4'h5 after the 3rd agreeing frame
//     (<=36+2+12 cycles); release -> key=4'hA 3 frames later.
//   3 '0' and '#' bouncing for 2 frames, then stable -> key stays 4'hA until 3 consecutive
//     stable frames, then key=4'h0/4'hC.
//   4 Press '1' and '9' together -> key stays 4'hA; release '9' -> key=4'h1 after 3 frames.
//   5 Hold '7', then slide to '8' without release -> key 4'h7 -> 4'h8, never 4'hA between.
//   6 With KEYSCAN_VALID_EN: press '3' -> exactly one key_valid pulse, coincident with
//     key=4'h3; hold 10 frames -> no further pulses; release -> no pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row synchroniser, column scan, ghost-rejecting frame tally and debounce.
// Optional `KEYSCAN_VALID_EN adds a key_valid pulse on every newly accepted digit/symbol key.
module keypad_scanner #(
  parameter int         SCAN_DIV        = 256,
  parameter int         DEBOUNCE_FRAMES = 4,
  parameter logic [3:0] NOKEY           = 4'hA
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] key
`ifdef KEYSCAN_VALID_EN
  ,
  output logic       key_valid
`endif
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST_DWELL = CNT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX    = DEB_W'(DEBOUNCE_FRAMES);

  logic [3:0]       rowSync1_q, rowSync2_q;
  logic [CNT_W-1:0] dwell_q;
  logic [1:0]       colIdx_q;
  logic [1:0]       tally_q, tally_d;
  logic [3:0]       accCode_q, accCode_d;
  logic [3:0]       cand_q, cand_d;
  logic [DEB_W-1:0] debCnt_q, debCnt_d;
  logic [3:0]       key_q;

  logic             lastDwell, frameEnd, keyLoad;
  logic [3:0]       pressed;
  logic [2:0]       hits;
  logic [2:0]       tallySum;
  logic [1:0]       rowSel;
  logic [3:0]       frameCode;

  function automatic logic [3:0] mapKey(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    if (r == 2'd3) begin
      case (c)
        2'd0:    code = 4'hB;
        2'd1:    code = 4'h0;
        default: code = 4'hC;
      endcase
    end else begin
      code = 4'(r) * 4'd3 + 4'(c) + 4'd1;
    end
    return code;
  endfunction

  assign col_n     = ~(3'b001 << colIdx_q);
  assign key       = key_q;
  assign lastDwell = (dwell_q == LAST_DWELL);
  assign frameEnd  = lastDwell && (colIdx_q == 2'd2);
  assign pressed   = ~rowSync2_q;

  // Tally saturates at 2 so any multi-key frame collapses to NOKEY.
  always_comb begin
    hits = {2'b00, pressed[0]} + {2'b00, pressed[1]} + {2'b00, pressed[2]} + {2'b00, pressed[3]};
    if (pressed[0])      rowSel = 2'd0;
    else if (pressed[1]) rowSel = 2'd1;
    else if (pressed[2]) rowSel = 2'd2;
    else                 rowSel = 2'd3;

    tallySum = {1'b0, tally_q} + hits;
    tally_d  = (tallySum >= 3'd2) ? 2'd2 : tallySum[1:0];
    accCode_d = accCode_q;
    if (tally_q == 2'd0 && hits == 3'd1) accCode_d = mapKey(rowSel, colIdx_q);
    frameCode = (tally_d == 2'd1) ? accCode_d : NOKEY;

    cand_d   = cand_q;
    debCnt_d = debCnt_q;
    if (frameCode == cand_q) begin
      if (debCnt_q != DEB_MAX) debCnt_d = debCnt_q + DEB_W'(1);
    end else begin
      cand_d   = frameCode;
      debCnt_d = DEB_W'(1);
    end
    keyLoad = frameEnd && (debCnt_d == DEB_MAX) && (cand_d != key_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rowSync1_q <= 4'hF;
      rowSync2_q <= 4'hF;
      dwell_q    <= '0;
      colIdx_q   <= 2'd0;
      tally_q    <= 2'd0;
      accCode_q  <= NOKEY;
      cand_q     <= NOKEY;
      debCnt_q   <= '0;
      key_q      <= NOKEY;
    end else begin
      rowSync1_q <= row_n;
      rowSync2_q <= rowSync1_q;
      if (lastDwell) begin
        dwell_q  <= '0;
        colIdx_q <= (colIdx_q == 2'd2) ? 2'd0 : colIdx_q + 2'd1;
        if (frameEnd) begin
          tally_q   <= 2'd0;
          accCode_q <= NOKEY;
          cand_q    <= cand_d;
          debCnt_q  <= debCnt_d;
        end else begin
          tally_q   <= tally_d;
          accCode_q <= accCode_d;
        end
      end else begin
        dwell_q <= dwell_q + CNT_W'(1);
      end
      if (keyLoad) key_q <= cand_d;
    end
  end

`ifdef KEYSCAN_VALID_EN
  logic keyValid_q;

  // Releases back to NOKEY are deliberately silent.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) keyValid_q <= 1'b0;
    else        keyValid_q <= keyLoad && (cand_d != NOKEY);
  end

  assign key_valid = keyValid_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (12-cycle frames).
// A behavioural keypad model drives row_n from a 12-bit pressed-key mask (bit = row*3+col).
module tb_keypad_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [3:0]  key;
  logic [11:0] pressMask = '0;
`ifdef KEYSCAN_VALID_EN
  logic        key_valid;
`endif

  int compared   = 0;
  int mismatched = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3), .NOKEY(4'hA)) dut (
    .clock (clock),
    .reset (reset),
    .row_n (row_n),
    .col_n (col_n),
    .key   (key)
`ifdef KEYSCAN_VALID_EN
    ,
    .key_valid (key_valid)
`endif
  );

  always #5 clock = ~clock;

  // Pressed switches short their row to whichever column is currently driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressMask[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  typedef struct {
    string       name;
    logic [11:0] mask;
    int          cycles;
    logic [3:0]  expKey;
  } vec_t;

  vec_t vecs[14];

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] m, input int n);
    pressMask = m;
    tick(n);
  endtask

  task automatic alignFrame();
    int budget;
    budget = 0;
    while (col_n != 3'b011 && budget < 40) begin tick(1); budget++; end
    while (col_n != 3'b110 && budget < 80) begin tick(1); budget++; end
    if (budget >= 80) checkOutput("alignTimeout", budget, 0);
  endtask

  initial begin
    logic [2:0] one;
    logic [2:0] colExp;
    int noKeySeen;
`ifdef KEYSCAN_VALID_EN
    int pulses;
    int misaligned;
`endif
    one = 3'b001;

    vecs[0]  = '{"idle",        12'h000, 60, 4'hA};
    vecs[1]  = '{"press5Early", 12'h010, 12, 4'hA};
    vecs[2]  = '{"press5",      12'h010, 48, 4'h5};
    vecs[3]  = '{"rel5Early",   12'h000, 12, 4'h5};
    vecs[4]  = '{"rel5",        12'h000, 48, 4'hA};
    vecs[5]  = '{"pressHash",   12'h800, 60, 4'hC};
    vecs[6]  = '{"relHash",     12'h000, 60, 4'hA};
    vecs[7]  = '{"ghost1and9",  12'h101, 60, 4'hA};
    vecs[8]  = '{"drop9Early",  12'h001, 12, 4'hA};
    vecs[9]  = '{"drop9",       12'h001, 48, 4'h1};
    vecs[10] = '{"rel1",        12'h000, 60, 4'hA};
    vecs[11] = '{"pressStar",   12'h200, 60, 4'hB};
    vecs[12] = '{"press3",      12'h004, 60, 4'h3};
    vecs[13] = '{"rel3",        12'h000, 60, 4'hA};

    tick(3);
    checkOutput("resetKey", int'(key), 'hA);
    checkOutput("resetCol", int'(col_n), 'b110);
`ifdef KEYSCAN_VALID_EN
    checkOutput("resetValid", int'(key_valid), 0);
`endif

    reset = 1'b1;
    applyStimulus(12'h010, 64);
    checkOutput("preResetKey", int'(key), 'h5);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    checkOutput("asyncResetCol", int'(col_n), 'b110);
    checkOutput("asyncResetKey", int'(key), 'hA);
    pressMask = '0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      colExp = ~(one << ((k / 4) % 3));
      checkOutput($sformatf("colStep%0d", k), int'(col_n), int'(colExp));
    end

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].mask, vecs[i].cycles);
      checkOutput(vecs[i].name, int'(key), int'(vecs[i].expKey));
    end

    // Frame-aligned bounce on '0': press, release, then hold.
    alignFrame();
    applyStimulus(12'h400, 12);
    applyStimulus(12'h000, 12);
    checkOutput("bounceDuring", int'(key), 'hA);
    applyStimulus(12'h400, 24);
    checkOutput("bounceTwoStable", int'(key), 'hA);
    tick(12);
    checkOutput("bounceAccept", int'(key), 'h0);
    applyStimulus(12'h000, 60);
    checkOutput("bounceRelease", int'(key), 'hA);

    applyStimulus(12'h040, 60);
    checkOutput("slideHold7", int'(key), 'h7);
    pressMask = 12'h080;
    noKeySeen = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (key == 4'hA) noKeySeen++;
    end
    checkOutput("slideNoGap", noKeySeen, 0);
    checkOutput("slideTo8", int'(key), 'h8);
    applyStimulus(12'h000, 60);
    checkOutput("slideRelease", int'(key), 'hA);

`ifdef KEYSCAN_VALID_EN
    pressMask = 12'h004;
    pulses = 0;
    misaligned = 0;
    for (int i = 0; i < 156; i++) begin
      tick(1);
      if (key_valid) begin
        pulses++;
        if (key != 4'h3) misaligned++;
      end
    end
    checkOutput("validPulses", pulses, 1);
    checkOutput("validCoincident", misaligned, 0);
    checkOutput("validKey3", int'(key), 'h3);
    pressMask = 12'h000;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (key_valid) pulses++;
    end
    checkOutput("validOnRelease", pulses, 0);
    checkOutput("validReleaseKey", int'(key), 'hA);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
